// File: rtl/dispense_ctrl.sv
// dispense_ctrl: keypad-driven grain order builder, validator and timed valve driver
module dispense_ctrl #(
  parameter int TICKS_PER_UNIT = 25000000,
  parameter int MAX_QTY = 20,
  parameter int DONE_HOLD = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [2:0] valve,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] product,
  output logic [7:0] qty_bcd,
  output logic [2:0] state
);
  localparam int TW = TICKS_PER_UNIT > 1 ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int DW = DONE_HOLD > 1 ? $clog2(DONE_HOLD) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TICKS_PER_UNIT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DONE_HOLD - 1);
  localparam logic [6:0] MQ = 7'(MAX_QTY);
  typedef enum logic [2:0] {IDLE = 3'd0, QTY = 3'd1, DISPENSE = 3'd2, DONE = 3'd3} state_t;
  state_t st;
  logic [1:0] cnt;
  logic [6:0] units;
  logic [TW-1:0] tick;
  logic [DW-1:0] hold;
  logic [6:0] qty_bin;
  logic is_digit, is_grain;
  assign state = st;
  assign qty_bin = {3'b0, qty_bcd[7:4]} * 7'd10 + {3'b0, qty_bcd[3:0]};
  assign is_digit = key_code <= 4'd9;
  assign is_grain = key_code inside {4'hA, 4'hB, 4'hC};
  always_ff @(posedge CLK) begin
    err <= 1'b0;
    if (RST) begin
      st <= IDLE;
      valve <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
      qty_bcd <= '0;
      cnt <= '0;
      units <= '0;
      tick <= '0;
      hold <= '0;
    end else begin
      case (st)
        IDLE: if (key_valid && is_grain) begin
          product <= 2'(key_code - 4'hA);
          qty_bcd <= '0;
          cnt <= '0;
          st <= QTY;
        end
        QTY: if (key_valid) begin
          if (is_digit) begin
            if (cnt == 2'd2) err <= 1'b1;
            else begin
              qty_bcd <= {qty_bcd[3:0], key_code};
              cnt <= cnt + 2'd1;
            end
          end else if (is_grain) begin
            product <= 2'(key_code - 4'hA);
          end else if (key_code == 4'hE) begin
            qty_bcd <= '0;
            cnt <= '0;
            st <= IDLE;
          end else if (key_code == 4'hF) begin
            if (qty_bin == 7'd0 || qty_bin > MQ) begin
              err <= 1'b1;
              qty_bcd <= '0;
              cnt <= '0;
            end else begin
              units <= qty_bin;
              tick <= '0;
              valve <= 3'b001 << product;
              busy <= 1'b1;
              st <= DISPENSE;
            end
          end
        end
        DISPENSE: if (tick == T_LAST && units == 7'd1) begin
          tick <= '0;
          units <= '0;
          valve <= '0;
          done <= 1'b1;
          hold <= '0;
          st <= DONE;
        end else if (key_valid && key_code == 4'hE) begin
          err <= 1'b1;
          qty_bcd <= '0;
          valve <= '0;
          busy <= 1'b0;
          st <= IDLE;
        end else begin
          tick <= tick == T_LAST ? '0 : tick + TW'(1);
          units <= tick == T_LAST ? units - 7'd1 : units;
        end
        DONE: if (hold == D_LAST) begin
          qty_bcd <= '0;
          done <= 1'b0;
          busy <= 1'b0;
          st <= IDLE;
        end else begin
          hold <= hold + DW'(1);
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dispense_ctrl.sv
// tb_dispense_ctrl: table-driven and sequence checks of dispense_ctrl through an expectation queue
module tb_dispense_ctrl;
  logic CLK = 1'b0;
  logic RST, key_valid;
  logic [3:0] key_code;
  logic [2:0] valve, state;
  logic busy, done, err;
  logic [1:0] product;
  logic [7:0] qty_bcd;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic kv;
    logic [3:0] k;
    logic [2:0] st;
    logic [7:0] q;
    logic [1:0] p;
    logic e;
    logic [2:0] v;
  } vec_t;
  vec_t sb[$];
  vec_t tbl[17];
  always #5 CLK = ~CLK;
  dispense_ctrl #(.TICKS_PER_UNIT(4), .MAX_QTY(20), .DONE_HOLD(3)) dut (
    .CLK(CLK), .RST(RST), .key_valid(key_valid), .key_code(key_code),
    .valve(valve), .busy(busy), .done(done), .err(err),
    .product(product), .qty_bcd(qty_bcd), .state(state)
  );
  function automatic vec_t mk(logic kv, logic [3:0] k, logic [2:0] st, logic [7:0] q, logic [1:0] p, logic e, logic [2:0] v);
    vec_t r;
    r.kv = kv;
    r.k = k;
    r.st = st;
    r.q = q;
    r.p = p;
    r.e = e;
    r.v = v;
    return r;
  endfunction
  task automatic chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask
  task automatic step(vec_t e);
    vec_t x;
    @(negedge CLK);
    key_valid = e.kv;
    key_code = e.k;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    key_valid = 1'b0;
    x = sb.pop_front();
    chk($sformatf("state k=%h", x.k), state, x.st);
    chk($sformatf("qty k=%h", x.k), qty_bcd, x.q);
    chk($sformatf("product k=%h", x.k), product, x.p);
    chk($sformatf("err k=%h", x.k), err, x.e);
    chk($sformatf("valve k=%h", x.k), valve, x.v);
    chk($sformatf("busy k=%h", x.k), busy, x.st == 3'd2 || x.st == 3'd3);
  endtask
  task automatic key(logic [3:0] k, logic [2:0] st, logic [7:0] q, logic [1:0] p, logic e, logic [2:0] v);
    step(mk(1'b1, k, st, q, p, e, v));
  endtask
  task automatic idle(logic [2:0] st, logic [7:0] q, logic [1:0] p, logic [2:0] v);
    step(mk(1'b0, 4'h0, st, q, p, 1'b0, v));
  endtask
  task automatic count_valve(logic [2:0] v, output int n);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      if (valve != v) break;
      n++;
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic count_done(output int n);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      if (!done) break;
      n++;
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic chk_reset(string n);
    chk({n, " valve"}, valve, 0);
    chk({n, " busy"}, busy, 0);
    chk({n, " done"}, done, 0);
    chk({n, " err"}, err, 0);
    chk({n, " product"}, product, 0);
    chk({n, " qty"}, qty_bcd, 0);
    chk({n, " state"}, state, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    tbl[0]  = mk(1, 4'hD, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 4'h5, 0, 8'h00, 0, 0, 0);
    tbl[2]  = mk(1, 4'hF, 0, 8'h00, 0, 0, 0);
    tbl[3]  = mk(1, 4'hA, 1, 8'h00, 0, 0, 0);
    tbl[4]  = mk(1, 4'h2, 1, 8'h02, 0, 0, 0);
    tbl[5]  = mk(1, 4'h5, 1, 8'h25, 0, 0, 0);
    tbl[6]  = mk(1, 4'hF, 1, 8'h00, 0, 1, 0);
    tbl[7]  = mk(0, 4'h0, 1, 8'h00, 0, 0, 0);
    tbl[8]  = mk(1, 4'hD, 1, 8'h00, 0, 0, 0);
    tbl[9]  = mk(1, 4'hC, 1, 8'h00, 2, 0, 0);
    tbl[10] = mk(1, 4'h0, 1, 8'h00, 2, 0, 0);
    tbl[11] = mk(1, 4'hF, 1, 8'h00, 2, 1, 0);
    tbl[12] = mk(1, 4'h1, 1, 8'h01, 2, 0, 0);
    tbl[13] = mk(1, 4'h2, 1, 8'h12, 2, 0, 0);
    tbl[14] = mk(1, 4'h3, 1, 8'h12, 2, 1, 0);
    tbl[15] = mk(1, 4'hB, 1, 8'h12, 1, 0, 0);
    tbl[16] = mk(1, 4'hE, 0, 8'h00, 1, 0, 0);
    RST = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset("reset");
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 17; i++) step(tbl[i]);
    key(4'hB, 1, 8'h00, 1, 0, 3'b000);
    key(4'h1, 1, 8'h01, 1, 0, 3'b000);
    key(4'h2, 1, 8'h12, 1, 0, 3'b000);
    key(4'hF, 2, 8'h12, 1, 0, 3'b010);
    count_valve(3'b010, n);
    chk("b12 valve cycles", n, 48);
    chk("b12 state done", state, 3);
    chk("b12 busy in done", busy, 1);
    count_done(n);
    chk("b12 done cycles", n, 3);
    chk("b12 state idle", state, 0);
    chk("b12 qty cleared", qty_bcd, 0);
    chk("b12 product kept", product, 1);
    chk("b12 busy low", busy, 0);
    key(4'hA, 1, 8'h00, 0, 0, 3'b000);
    key(4'h2, 1, 8'h02, 0, 0, 3'b000);
    key(4'h5, 1, 8'h25, 0, 0, 3'b000);
    key(4'hF, 1, 8'h00, 0, 1, 3'b000);
    idle(1, 8'h00, 0, 3'b000);
    key(4'h3, 1, 8'h03, 0, 0, 3'b000);
    key(4'hF, 2, 8'h03, 0, 0, 3'b001);
    count_valve(3'b001, n);
    chk("a3 valve cycles", n, 12);
    count_done(n);
    chk("a3 done cycles", n, 3);
    key(4'hA, 1, 8'h00, 0, 0, 3'b000);
    key(4'h1, 1, 8'h01, 0, 0, 3'b000);
    key(4'hF, 2, 8'h01, 0, 0, 3'b001);
    repeat (3) idle(2, 8'h01, 0, 3'b001);
    key(4'hE, 3, 8'h01, 0, 0, 3'b000);
    chk("terminal tick done", done, 1);
    key(4'hA, 3, 8'h01, 0, 0, 3'b000);
    count_done(n);
    chk("terminal done rest", n, 2);
    chk("terminal idle", state, 0);
    key(4'hA, 1, 8'h00, 0, 0, 3'b000);
    key(4'h9, 1, 8'h09, 0, 0, 3'b000);
    key(4'hF, 2, 8'h09, 0, 0, 3'b001);
    repeat (9) idle(2, 8'h09, 0, 3'b001);
    key(4'hE, 0, 8'h00, 0, 1, 3'b000);
    idle(0, 8'h00, 0, 3'b000);
    key(4'hC, 1, 8'h00, 2, 0, 3'b000);
    key(4'h5, 1, 8'h05, 2, 0, 3'b000);
    key(4'hF, 2, 8'h05, 2, 0, 3'b100);
    repeat (2) idle(2, 8'h05, 2, 3'b100);
    @(negedge CLK);
    RST = 1'b1;
    key_valid = 1'b1;
    key_code = 4'hF;
    @(posedge CLK);
    #1;
    key_valid = 1'b0;
    chk_reset("rst in dispense");
    @(negedge CLK);
    RST = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
